encoder4_2: RTL and testbench

Registered 4-to-2 encoder that turns a one-hot 4-bit code `y1` back into its 2-bit index `a1`; it is the inverse of `decoder2_4` and is used to check decoder output round-trips. Input words enter through a valid/ready handshake and are buffered in a small first-word-fall-through FIFO. Each output word carries an error flag for non-one-hot input. A saturating counter reports how many malformed words were accepted.

---
 rtl/encoder4_2.sv | 96 +++++++++
 tb/tb_encoder4_2.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/encoder4_2.sv
// One-hot to binary encoder with a valid/ready front end and a small FWFT FIFO.
// Each entry carries an error flag for non-one-hot codes; malformed words are counted.
module encoder4_2 #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       y1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [1:0]       a1,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(DEPTH);

    // Multi-hot codes resolve to the highest set bit; all-zero resolves to 0.
    function automatic logic [2:0] encode(input logic [3:0] y);
        logic [2:0] e;
        casez (y)
            4'b1???: e[1:0] = 2'd3;
            4'b01??: e[1:0] = 2'd2;
            4'b001?: e[1:0] = 2'd1;
            default: e[1:0] = 2'd0;
        endcase
        e[2] = !((y != 4'd0) && ((y & (y - 4'd1)) == 4'd0));
        return e;
    endfunction

    logic [2:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [2:0]       entry;
    logic [2:0]       head;
    logic             push, pop;

    assign entry     = encode(y1);
    assign in_ready  = (count_q < DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];
    assign a1        = out_valid ? head[1:0] : 2'd0;
    assign err       = out_valid ? head[2] : 1'b0;
    assign err_cnt   = err_cnt_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
        if (push && entry[2] && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage is not reset; a stale write during rst is harmless since count is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

endmodule

// File: tb/tb_encoder4_2.sv
// Scoreboard bench for encoder4_2: a queue model predicts every output cycle,
// with a second instance at CNT_W=2 to exercise counter saturation.
module tb_encoder4_2;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] y1 = 4'd0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, err;
    logic [1:0] a1;
    logic [7:0] err_cnt;
    logic       in_ready_s, out_valid_s, err_s;
    logic [1:0] a1_s;
    logic [1:0] err_cnt_s;

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    logic [2:0] sb[$];
    int         exp_cnt8 = 0;
    int         exp_cnt2 = 0;

    always #5 clk = ~clk;

    encoder4_2 #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .y1(y1), .in_valid(in_valid), .in_ready(in_ready),
        .a1(a1), .err(err), .out_valid(out_valid), .out_ready(out_ready), .err_cnt(err_cnt)
    );

    encoder4_2 #(.DEPTH(DEPTH), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .y1(y1), .in_valid(in_valid), .in_ready(in_ready_s),
        .a1(a1_s), .err(err_s), .out_valid(out_valid_s), .out_ready(out_ready), .err_cnt(err_cnt_s)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] enc_ref(input logic [3:0] y);
        logic [1:0] idx;
        int         n;
        idx = 2'd0;
        n   = 0;
        for (int b = 0; b < 4; b++) begin
            if (y[b]) begin
                idx = 2'(b);
                n++;
            end
        end
        return {(n != 1), idx};
    endfunction

    task automatic check_outputs();
        logic [2:0] hd;
        logic       ov;
        ov = (sb.size() != 0);
        hd = ov ? sb[0] : 3'd0;
        check("out_valid", 32'(out_valid), 32'(ov));
        check("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
        check("a1", 32'(a1), 32'(hd[1:0]));
        check("err", 32'(err), 32'(hd[2]));
        check("err_cnt", 32'(err_cnt), 32'(exp_cnt8));
        check("out_valid_s", 32'(out_valid_s), 32'(ov));
        check("a1_s", 32'(a1_s), 32'(hd[1:0]));
        check("err_cnt_s", 32'(err_cnt_s), 32'(exp_cnt2));
    endtask

    task automatic step(input logic [3:0] y, input logic iv, input logic ordy, input logic r);
        logic [2:0] e;
        logic       do_push, do_pop;
        @(negedge clk);
        if (armed) check_outputs();
        y1 = y;
        in_valid = iv;
        out_ready = ordy;
        rst = r;
        do_push = !r && iv && (sb.size() < DEPTH);
        do_pop  = !r && ordy && (sb.size() != 0);
        if (do_pop) begin
            e = sb.pop_front();
            check("pop_a1", 32'(a1), 32'(e[1:0]));
            check("pop_err", 32'(err), 32'(e[2]));
        end
        if (r) begin
            sb.delete();
            exp_cnt8 = 0;
            exp_cnt2 = 0;
        end
        if (do_push) begin
            e = enc_ref(y);
            sb.push_back(e);
            if (e[2]) begin
                if (exp_cnt8 < 255) exp_cnt8++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
        end
        @(posedge clk);
        if (r) armed = 1'b1;
    endtask

    logic [3:0] onehot_tab[4];
    logic [3:0] bad_tab[5];
    int         sat_seq[5];
    logic [3:0] rv;

    initial begin
        onehot_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        bad_tab    = '{4'b0000, 4'b0110, 4'b1111, 4'b0011, 4'b1010};
        sat_seq    = '{1, 2, 3, 3, 3};

        step(4'b0001, 1'b1, 1'b1, 1'b1);
        step(4'b0001, 1'b1, 1'b1, 1'b1);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);

        for (int i = 0; i < 4; i++) step(onehot_tab[i], 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(bad_tab[i], 1'b1, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        #1 check("err_cnt_three", 32'(err_cnt), 32'd3);

        step(4'b0100, 1'b1, 1'b0, 1'b0);
        step(4'b1000, 1'b1, 1'b0, 1'b0);
        #1 check("full_in_ready", 32'(in_ready), 32'd0);
        step(4'b0001, 1'b1, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0, 1'b0);
        #1 check("held_a1", 32'(a1), 32'd2);
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        #1 check("ready_after_pop", 32'(in_ready), 32'd1);
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            rv = 4'b0001 << $urandom_range(0, 3);
            step(rv, 1'b1, 1'b1, 1'b0);
        end
        step(4'b0000, 1'b0, 1'b1, 1'b0);

        step(4'b0000, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(bad_tab[i], 1'b1, 1'b1, 1'b0);
            #1 check("sat_seq", 32'(err_cnt_s), 32'(sat_seq[i]));
        end
        step(4'b0000, 1'b0, 1'b1, 1'b0);

        step(4'b0010, 1'b1, 1'b0, 1'b0);
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b1, 1'b1);
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_a1", 32'(a1), 32'd0);
        check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
